// File: rtl/sync_fifo_pkg.sv
// Shared types and elaboration helpers for the sync_fifo slice.
// Imported by both the storage array and the FIFO top level.
package sync_fifo_pkg;

  typedef enum logic {
    RD_FWFT = 1'b0,
    RD_REG  = 1'b1
  } rd_mode_e;

  function automatic int depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic bit params_legal(input int addrsize, input int afull, input int aempty,
                                      input int rd_reg, input int drop_every);
    return (addrsize >= 1) &&
           (afull >= 1) && (afull <= depth(addrsize)) &&
           (aempty >= 0) && (aempty < depth(addrsize)) &&
           ((rd_reg == 0) || (rd_reg == 1)) &&
           (drop_every >= 0);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one write port, one asynchronous read port.
// Contents are never reset; the pointers alone decide what is valid.
module sync_fifo_ram #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);
  import sync_fifo_pkg::*;

  localparam int DEPTH = depth(ADDRSIZE);

  logic [DATASIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy thresholds, sticky error flags,
// selectable FWFT/registered read and a deterministic write-drop injector.
module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int RD_REG        = 0,
  parameter int DROP_EVERY    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                walmost_full,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  input  logic                err_clr,
  output logic                overflow,
  output logic                underflow
);
  import sync_fifo_pkg::*;

  localparam int       DEPTH = depth(ADDRSIZE);
  localparam int       PW    = ADDRSIZE + 1;
  localparam rd_mode_e MODE  = (RD_REG != 0) ? sync_fifo_pkg::RD_REG : sync_fifo_pkg::RD_FWFT;

  if (!params_legal(ADDRSIZE, AFULL_THRESH, AEMPTY_THRESH, RD_REG, DROP_EVERY)) begin : g_bad_params
    $error("sync_fifo: illegal parameter set");
  end

  logic [PW-1:0]       wptr_reg;
  logic [PW-1:0]       rptr_reg;
  logic [PW-1:0]       occupancy;
  logic                wr_acc;
  logic                rd_acc;
  logic                drop_hit;
  logic                mem_we;
  logic                overflow_reg;
  logic                underflow_reg;
  logic [DATASIZE-1:0] ram_rdata;

  // Extra pointer bit makes full (DEPTH) and empty (0) distinct after wrap.
  assign occupancy     = wptr_reg - rptr_reg;
  assign count         = occupancy;
  assign wfull         = (occupancy == PW'(DEPTH));
  assign rempty        = (occupancy == '0);
  assign walmost_full  = (occupancy >= PW'(AFULL_THRESH));
  assign ralmost_empty = (occupancy <= PW'(AEMPTY_THRESH));
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;

  assign wr_acc = winc && !wfull;
  assign rd_acc = rinc && !rempty;
  assign mem_we = wr_acc && !drop_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) wptr_reg <= wptr_reg + PW'(1);
      if (rd_acc) rptr_reg <= rptr_reg + PW'(1);
      // A new error in the same cycle as err_clr keeps the flag set.
      if (winc && wfull)        overflow_reg <= 1'b1;
      else if (err_clr)         overflow_reg <= 1'b0;
      if (rinc && rempty)       underflow_reg <= 1'b1;
      else if (err_clr)         underflow_reg <= 1'b0;
    end
  end

  if (DROP_EVERY > 0) begin : g_drop
    localparam int             DCW  = (DROP_EVERY > 1) ? $clog2(DROP_EVERY) : 1;
    localparam logic [DCW-1:0] LAST = DCW'(DROP_EVERY - 1);

    logic [DCW-1:0] drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drop_cnt_reg <= '0;
      end else if (wr_acc) begin
        drop_cnt_reg <= (drop_cnt_reg == LAST) ? '0 : drop_cnt_reg + DCW'(1);
      end
    end

    // Dropped writes still advance wptr; only the storage update is suppressed.
    assign drop_hit = wr_acc && (drop_cnt_reg == LAST);
  end else begin : g_no_drop
    assign drop_hit = 1'b0;
  end

  sync_fifo_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_reg[ADDRSIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_reg[ADDRSIZE-1:0]),
    .rdata (ram_rdata)
  );

  if (MODE == sync_fifo_pkg::RD_REG) begin : g_rd_reg
    logic [DATASIZE-1:0] rdata_reg;
    logic                rvalid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_reg  <= '0;
        rvalid_reg <= 1'b0;
      end else begin
        rvalid_reg <= rd_acc;
        if (rd_acc) rdata_reg <= ram_rdata;
      end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
  end else begin : g_fwft
    assign rdata  = ram_rdata;
    assign rvalid = !rempty;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed checks of sync_fifo against a queue-based model,
// using FWFT, registered-read and drop-every-3 instances side by side.
module tb_sync_fifo;

  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a: FWFT, no fault injection
  logic       winc_a = 0, rinc_a = 0, err_clr_a = 0;
  logic [7:0] wdata_a = 0, rdata_a;
  logic       wfull_a, walmost_full_a, rvalid_a, rempty_a, ralmost_empty_a, overflow_a, underflow_a;
  logic [4:0] count_a;
  // Instance r: registered read
  logic       winc_r = 0, rinc_r = 0, err_clr_r = 0;
  logic [7:0] wdata_r = 0, rdata_r;
  logic       wfull_r, walmost_full_r, rvalid_r, rempty_r, ralmost_empty_r, overflow_r, underflow_r;
  logic [4:0] count_r;
  // Instance d: every third accepted write dropped
  logic       winc_d = 0, rinc_d = 0, err_clr_d = 0;
  logic [7:0] wdata_d = 0, rdata_d;
  logic       wfull_d, walmost_full_d, rvalid_d, rempty_d, ralmost_empty_d, overflow_d, underflow_d;
  logic [4:0] count_d;

  sync_fifo #(.RD_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .winc(winc_a), .wdata(wdata_a), .wfull(wfull_a),
    .walmost_full(walmost_full_a), .rinc(rinc_a), .rdata(rdata_a), .rvalid(rvalid_a),
    .rempty(rempty_a), .ralmost_empty(ralmost_empty_a), .count(count_a),
    .err_clr(err_clr_a), .overflow(overflow_a), .underflow(underflow_a)
  );

  sync_fifo #(.RD_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .winc(winc_r), .wdata(wdata_r), .wfull(wfull_r),
    .walmost_full(walmost_full_r), .rinc(rinc_r), .rdata(rdata_r), .rvalid(rvalid_r),
    .rempty(rempty_r), .ralmost_empty(ralmost_empty_r), .count(count_r),
    .err_clr(err_clr_r), .overflow(overflow_r), .underflow(underflow_r)
  );

  sync_fifo #(.DROP_EVERY(3)) dut_d (
    .clk(clk), .rst_n(rst_n), .winc(winc_d), .wdata(wdata_d), .wfull(wfull_d),
    .walmost_full(walmost_full_d), .rinc(rinc_d), .rdata(rdata_d), .rvalid(rvalid_d),
    .rempty(rempty_d), .ralmost_empty(ralmost_empty_d), .count(count_d),
    .err_clr(err_clr_d), .overflow(overflow_d), .underflow(underflow_d)
  );

  // Reference state
  logic [7:0] mq[$];
  bit         ovf_m = 0, unf_m = 0;
  int         nr = 0, nd = 0, widx = 0;
  logic [7:0] dexp [6];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_flags(input string p, input int n, input logic [4:0] cnt,
                           input logic wf, input logic re, input logic af, input logic ae,
                           input logic ov, input logic un, input bit eov, input bit eun);
    chk({p, "_count"},  32'(cnt), 32'(n));
    chk({p, "_wfull"},  32'(wf),  32'(n == DEPTH));
    chk({p, "_rempty"}, 32'(re),  32'(n == 0));
    chk({p, "_afull"},  32'(af),  32'(n >= DEPTH - 2));
    chk({p, "_aempty"}, 32'(ae),  32'(n <= 2));
    chk({p, "_ovf"},    32'(ov),  32'(eov));
    chk({p, "_unf"},    32'(un),  32'(eun));
  endtask

  task automatic step_a(input logic w, input logic r, input logic [7:0] d, input logic clr);
    int n = mq.size();
    if (r && n != 0) chk("a_rdata", 32'(rdata_a), 32'(mq[0]));
    winc_a = w; rinc_a = r; wdata_a = d; err_clr_a = clr;
    @(posedge clk); #1;
    winc_a = 0; rinc_a = 0; err_clr_a = 0;
    if (r && n != 0) void'(mq.pop_front());
    if (w && n != DEPTH) mq.push_back(d);
    if (w && n == DEPTH) ovf_m = 1; else if (clr) ovf_m = 0;
    if (r && n == 0)     unf_m = 1; else if (clr) unf_m = 0;
    $display("a: t=%0t w=%0b r=%0b clr=%0b d=%02h cnt=%0d", $time, w, r, clr, d, mq.size());
    chk_flags("a", mq.size(), count_a, wfull_a, rempty_a, walmost_full_a, ralmost_empty_a,
              overflow_a, underflow_a, ovf_m, unf_m);
    chk("a_rvalid", 32'(rvalid_a), 32'(mq.size() != 0));
  endtask

  task automatic step_r(input logic w, input logic r, input logic [7:0] d);
    bit wacc = w && (nr != DEPTH);
    bit racc = r && (nr != 0);
    winc_r = w; rinc_r = r; wdata_r = d;
    @(posedge clk); #1;
    winc_r = 0; rinc_r = 0;
    nr = nr + int'(wacc) - int'(racc);
    $display("r: t=%0t w=%0b r=%0b d=%02h cnt=%0d", $time, w, r, d, nr);
    chk_flags("r", nr, count_r, wfull_r, rempty_r, walmost_full_r, ralmost_empty_r,
              overflow_r, underflow_r, 1'b0, 1'b0);
  endtask

  task automatic step_d(input logic w, input logic r, input logic [7:0] d);
    bit wacc = w && (nd != DEPTH);
    bit racc = r && (nd != 0);
    winc_d = w; rinc_d = r; wdata_d = d;
    @(posedge clk); #1;
    winc_d = 0; rinc_d = 0;
    nd = nd + int'(wacc) - int'(racc);
    if (wacc) begin
      widx++;
      if (widx % 3 == 0) $display("drop: t=%0t idx=%0d data=%02h", $time, widx, d);
    end
    $display("d: t=%0t w=%0b r=%0b d=%02h cnt=%0d", $time, w, r, d, nd);
    chk_flags("d", nd, count_d, wfull_d, rempty_d, walmost_full_d, ralmost_empty_d,
              overflow_d, underflow_d, 1'b0, 1'b0);
    chk("d_rvalid", 32'(rvalid_d), 32'(nd != 0));
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    mq.delete(); ovf_m = 0; unf_m = 0; nr = 0; nd = 0; widx = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    dexp = '{8'h01, 8'h02, 8'hFF, 8'h04, 8'h05, 8'hFF};
    do_reset();
    chk_flags("a_rst", 0, count_a, wfull_a, rempty_a, walmost_full_a, ralmost_empty_a,
              overflow_a, underflow_a, 1'b0, 1'b0);
    chk("a_rvalid_rst", 32'(rvalid_a), 32'(0));
    chk("r_rvalid_rst", 32'(rvalid_r), 32'(0));
    chk("r_rdata_rst",  32'(rdata_r),  32'(0));

    // Fill, overflow, error clear behaviour, drain, underflow
    for (int i = 0; i < 16; i++) step_a(1, 0, 8'(i), 0);
    step_a(1, 0, 8'hEE, 0);
    step_a(0, 0, 8'h00, 1);
    step_a(1, 0, 8'h77, 1);
    step_a(0, 0, 8'h00, 1);
    while (mq.size() > 0) step_a(0, 1, 8'h00, 0);
    step_a(0, 1, 8'h00, 0);
    step_a(0, 0, 8'h00, 1);

    // Simultaneous read/write at empty, then at full
    step_a(1, 1, 8'h55, 0);
    step_a(0, 0, 8'h00, 1);
    while (mq.size() < 16) step_a(1, 0, 8'($urandom), 0);
    step_a(1, 1, 8'h99, 0);
    step_a(0, 0, 8'h00, 1);

    // Steady occupancy of 5 across two pointer wraps
    while (mq.size() > 5) step_a(0, 1, 8'h00, 0);
    for (int i = 0; i < 40; i++) step_a(1, 1, 8'($urandom), 0);

    // Random traffic: write-heavy, then read-heavy
    for (int i = 0; i < 240; i++) begin
      logic w, r, c;
      w = ($urandom_range(0, 3) != 0) ^ (i >= 120);
      r = ($urandom_range(0, 3) == 0) ^ (i >= 120);
      c = ($urandom_range(0, 15) == 0);
      step_a(w, r, 8'($urandom), c);
    end

    // Asynchronous reset in mid-cycle at count 9 with underflow set
    while (mq.size() > 0) step_a(0, 1, 8'h00, 0);
    step_a(0, 1, 8'h00, 0);
    for (int i = 0; i < 9; i++) step_a(1, 0, 8'($urandom), 0);
    #2 rst_n = 0;
    #1;
    chk_flags("a_arst", 0, count_a, wfull_a, rempty_a, walmost_full_a, ralmost_empty_a,
              overflow_a, underflow_a, 1'b0, 1'b0);
    mq.delete(); ovf_m = 0; unf_m = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    step_a(1, 0, 8'h3C, 0);
    step_a(0, 1, 8'h00, 0);

    // Registered-read latency
    step_r(1, 0, 8'hA5);
    step_r(0, 0, 8'h00);
    chk("r_rvalid_idle", 32'(rvalid_r), 32'(0));
    step_r(0, 1, 8'h00);
    chk("r_rdata_k1",  32'(rdata_r),  32'(8'hA5));
    chk("r_rvalid_k1", 32'(rvalid_r), 32'(1));
    step_r(0, 0, 8'h00);
    chk("r_rvalid_k2", 32'(rvalid_r), 32'(0));
    chk("r_rdata_hold", 32'(rdata_r), 32'(8'hA5));
    step_r(1, 0, 8'h3C);
    step_r(1, 0, 8'h5A);
    step_r(0, 1, 8'h00);
    chk("r_rdata_b2b0", 32'(rdata_r), 32'(8'h3C));
    chk("r_rvalid_b2b0", 32'(rvalid_r), 32'(1));
    step_r(0, 1, 8'h00);
    chk("r_rdata_b2b1", 32'(rdata_r), 32'(8'h5A));
    chk("r_rvalid_b2b1", 32'(rvalid_r), 32'(1));

    // Drop injector: second lap puts 0xFF in locations 2 and 5, then reset
    do_reset();
    for (int i = 0; i < 16; i++) step_d(1, 0, 8'hFF);
    for (int i = 0; i < 16; i++) step_d(0, 1, 8'h00);
    for (int i = 0; i < 6; i++)  step_d(1, 0, 8'hFF);
    do_reset();
    for (int i = 1; i <= 6; i++) step_d(1, 0, 8'(i));
    for (int i = 0; i < 6; i++) begin
      chk("d_rdata", 32'(rdata_d), 32'(dexp[i]));
      step_d(0, 1, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
